// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decodes the RV immediate for R/I/S/B/U/J formats,
// registers it, and buffers it in a two-entry output + skid stage with valid/ready on both sides.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_enc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_enc_err
);

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             err;
   } entry_t;

   fmt_e        w_fmt;
   logic [31:0] w_imm32;
   logic        w_enc_err;
   entry_t      w_in_entry;
   logic        w_accept;
   logic        w_advance;

   entry_t      r_out;
   entry_t      r_skid;
   logic        r_out_valid;
   logic        r_skid_valid;

   assign w_fmt = fmt_e'(in_enc);

   // Every format carries its sign in instr[31], so a 32-bit form is built first and widened below.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
      w_imm32   = '0;
      w_enc_err = 1'b0;
      case (w_fmt)
         FMT_R: w_imm32 = '0;
         FMT_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U: w_imm32 = {in_instr[31:12], 12'b0};
         FMT_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
         default: w_enc_err = 1'b1;
      endcase
   end

   assign w_in_entry.imm = XLEN'($signed(w_imm32));
   assign w_in_entry.tag = in_tag;
   assign w_in_entry.err = w_enc_err;

   // in_ready depends only on the skid register, so out_ready never reaches upstream combinationally.
   assign in_ready  = !r_skid_valid;
   assign w_accept  = in_valid && in_ready;
   assign w_advance = !r_out_valid || out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state uses non-blocking assignments; payload registers are reset too so out_* read 0 after reset.
      if (!reset_n) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_out        <= '0;
         r_skid       <= '0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_advance) begin
         if (r_skid_valid) begin
            r_out        <= r_skid;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
         end else begin
            r_out_valid <= w_accept;
            if (w_accept) r_out <= w_in_entry;
         end
      end else if (w_accept) begin
         r_skid       <= w_in_entry;
         r_skid_valid <= 1'b1;
      end
   end

   assign out_valid   = r_out_valid;
   assign out_imm     = r_out.imm;
   assign out_tag     = r_out.tag;
   assign out_enc_err = r_out.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed and scoreboard bench for imm_gen_pipe; one XLEN=32 and one XLEN=64 instance share all inputs.
module tb_imm_gen_pipe;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [2:0]  in_enc;
   logic [4:0]  in_tag;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, err_a;
   logic [31:0] imm_a;
   logic [4:0]  tag_a;
   logic        in_ready_b, out_valid_b, err_b;
   logic [63:0] imm_b;
   logic [4:0]  tag_b;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [63:0] imm;
      logic [4:0]  tag;
      logic        err;
   } exp_t;

   exp_t q[$];

   imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr),
      .in_enc(in_enc), .in_tag(in_tag),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(imm_a),
      .out_tag(tag_a), .out_enc_err(err_a)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr),
      .in_enc(in_enc), .in_tag(in_tag),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(imm_b),
      .out_tag(tag_b), .out_enc_err(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference immediate built with arithmetic shifts rather than bit concatenation.
   function automatic logic [63:0] ref_imm(input logic [2:0] enc, input logic [31:0] ins);
      logic signed [63:0] sx;
      logic [63:0]        r;
      sx = $signed({{32{ins[31]}}, ins});
      case (enc)
         3'd1: r = 64'(sx >>> 20);
         3'd2: r = 64'((sx >>> 25) <<< 5) | 64'(ins[11:7]);
         3'd3: r = 64'((sx >>> 31) <<< 12) | (64'(ins[7]) << 11) |
                   (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
         3'd4: r = 64'(sx) & ~64'hFFF;
         3'd5: r = 64'((sx >>> 31) <<< 20) | (64'(ins[19:12]) << 12) |
                   (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
         default: r = '0;
      endcase
      return r;
   endfunction

   // Called #1 after a rising edge; presents one entry for exactly one edge.
   task automatic push(input logic [2:0] enc, input logic [31:0] ins, input logic [4:0] tag);
      in_valid = 1'b1;
      in_enc   = enc;
      in_instr = ins;
      in_tag   = tag;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      int   accepted;
      int   cyc;
      exp_t e;

      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_enc    = '0;
      in_tag    = '0;
      out_ready = 1'b1;

      #3;
      check("rst_out_valid", 128'(out_valid_a), 128'(0));
      check("rst_in_ready",  128'(in_ready_a),  128'(1));
      check("rst_payload_a", 128'({err_a, tag_a, imm_a}), 128'(0));
      check("rst_payload_b", 128'({err_b, tag_b, imm_b}), 128'(0));
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Formats, back-to-back so output handshake and new accept coincide.
      push(3'd1, 32'hFFF00093, 5'd1);
      check("i_a",       128'(imm_a), 128'(32'hFFFF_FFFF));
      check("i_b",       128'(imm_b), 128'(64'hFFFF_FFFF_FFFF_FFFF));
      check("i_valid",   128'({out_valid_a, tag_a, err_a}), 128'({1'b1, 5'd1, 1'b0}));
      push(3'd3, 32'hFE000EE3, 5'd2);
      check("b_a",       128'(imm_a), 128'(32'hFFFF_FFFC));
      check("b_valid",   128'({out_valid_a, tag_a}), 128'({1'b1, 5'd2}));
      push(3'd5, 32'h0010006F, 5'd3);
      check("j_a",       128'(imm_a), 128'(32'h0000_0800));
      push(3'd4, 32'h80000037, 5'd4);
      check("u_a",       128'(imm_a), 128'(32'h8000_0000));
      check("u_b",       128'(imm_b), 128'(64'hFFFF_FFFF_8000_0000));
      push(3'd2, 32'h00A12423, 5'd5);
      check("s_a",       128'(imm_a), 128'(32'h0000_0008));
      push(3'd0, 32'h00B50533, 5'd6);
      check("r_a",       128'({err_a, imm_a}), 128'(0));
      push(3'd7, 32'hFFFFFFFF, 5'd7);
      check("enc7_a",    128'({err_a, imm_a}), 128'({1'b1, 32'h0}));
      check("enc7_b",    128'({err_b, imm_b}), 128'({1'b1, 64'h0}));
      push(3'd6, 32'h80000037, 5'd8);
      check("enc6_b",    128'({err_b, tag_b, imm_b}), 128'({1'b1, 5'd8, 64'h0}));
      tick();
      check("drain_empty", 128'(out_valid_a), 128'(0));

      // Backpressure: two entries fill output + skid, third is held off.
      out_ready = 1'b0;
      push(3'd1, 32'h00100093, 5'd1);
      push(3'd1, 32'h00200093, 5'd2);
      check("full_in_ready", 128'(in_ready_a), 128'(0));
      in_valid = 1'b1; in_enc = 3'd1; in_instr = 32'h00300093; in_tag = 5'd3;
      tick();
      check("held_tag1", 128'({out_valid_a, tag_a, imm_a}), 128'({1'b1, 5'd1, 32'd1}));
      check("held_ready", 128'(in_ready_a), 128'(0));
      out_ready = 1'b1;
      tick();
      check("order_tag2", 128'({out_valid_a, tag_a, imm_a}), 128'({1'b1, 5'd2, 32'd2}));
      check("skid_freed", 128'(in_ready_a), 128'(1));
      tick();
      in_valid = 1'b0;
      check("order_tag3", 128'({out_valid_a, tag_a, imm_a}), 128'({1'b1, 5'd3, 32'd3}));
      tick();
      check("order_done", 128'(out_valid_a), 128'(0));

      // Flush with the buffer full, then with an accept in the same cycle.
      out_ready = 1'b0;
      push(3'd1, 32'h00400093, 5'd4);
      push(3'd1, 32'h00500093, 5'd5);
      flush = 1'b1; in_valid = 1'b1; in_enc = 3'd1; in_tag = 5'd6;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_full", 128'({out_valid_a, in_ready_a}), 128'({1'b0, 1'b1}));
      push(3'd1, 32'h00700093, 5'd7);
      flush = 1'b1; in_valid = 1'b1; in_tag = 5'd8;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      out_ready = 1'b1;
      check("flush_accept", 128'({out_valid_a, in_ready_a}), 128'({1'b0, 1'b1}));
      tick(); tick(); tick();
      check("flush_no_ghost", 128'({out_valid_a, out_valid_b}), 128'(0));

      // Asynchronous reset in the middle of a cycle with the buffer full.
      out_ready = 1'b0;
      push(3'd1, 32'h00900093, 5'd9);
      push(3'd1, 32'h00A00093, 5'd10);
      in_valid = 1'b1; in_tag = 5'd11;
      #2 reset_n = 1'b0;
      #1;
      check("midrst_valid", 128'({out_valid_a, out_valid_b}), 128'(0));
      check("midrst_ready", 128'(in_ready_a), 128'(1));
      in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("postrst_empty", 128'(out_valid_a), 128'(0));

      // Random traffic against a scoreboard queue.
      accepted = 0;
      cyc      = 0;
      while ((accepted < 10000 || q.size() != 0) && cyc < 60000) begin
         in_valid  = (accepted < 10000) && ($urandom_range(0, 9) < 7);
         in_instr  = $urandom();
         in_enc    = 3'($urandom_range(0, 7));
         in_tag    = 5'($urandom());
         out_ready = (accepted >= 10000) || ($urandom_range(0, 9) < 6);
         @(negedge clk);
         if (out_valid_a && out_ready) begin
            if (q.size() == 0) begin
               check("rnd_spurious", 128'(out_valid_a), 128'(0));
            end else begin
               e = q.pop_front();
               check("rnd_a", 128'({err_a, tag_a, imm_a}), 128'({e.err, e.tag, e.imm[31:0]}));
               check("rnd_b", 128'({out_valid_b, err_b, tag_b, imm_b}), 128'({1'b1, e.err, e.tag, e.imm}));
            end
         end
         if (in_valid && in_ready_a) begin
            q.push_back('{imm: ref_imm(in_enc, in_instr), tag: in_tag, err: (in_enc > 3'd5)});
            accepted++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      check("rnd_complete", 128'({accepted == 10000, q.size() == 0}), 128'(2'b11));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
